// File: rtl/percept_sched.sv
// Perceptron evaluation sequencer: arbitrates two requesters and steps the datapath strobes.
// Latency: grant at the edge after req; CLR..DONE spans 2 + 3n + RES_BITS cycles.
// No backpressure: req is level-sensitive and ignored while busy; abort cancels at the next edge.
module percept_sched #(
    parameter int N_MAX    = 16,
    parameter int RES_BITS = 8
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic [1:0] req,
    input  logic [4:0] n_in0,
    input  logic [4:0] n_in1,
    input  logic       abort,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic       clr,
    output logic       shift,
    output logic       mul,
    output logic       acc,
    output logic       shift_res,
    output logic [3:0] idx,
    output logic       busy
);

    localparam int CW = (RES_BITS > 1) ? $clog2(RES_BITS) : 1;
    localparam logic [CW-1:0] RES_LD = CW'(RES_BITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        SHIFT = 3'd2,
        MUL   = 3'd3,
        ACC   = 3'd4,
        RES   = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t        state, ns;
    logic [4:0]    n_q, n_nx, n_sel;
    logic [3:0]    idx_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          last_gnt, last_nx;
    logic          g_q, g_nx;

    always_comb begin
        ns      = state;
        n_nx    = n_q;
        n_sel   = n_in0;
        idx_nx  = idx;
        cnt_nx  = cnt;
        last_nx = last_gnt;
        g_nx    = g_q;
        case (state)
            IDLE: begin
                if (!abort && req != 2'b00) begin
                    // Tie goes to whichever requester was not served last.
                    g_nx    = (req == 2'b11) ? ~last_gnt : req[1];
                    last_nx = g_nx;
                    n_sel   = g_nx ? n_in1 : n_in0;
                    n_nx    = (n_sel > 5'(N_MAX)) ? 5'(N_MAX) : n_sel;
                    idx_nx  = 4'd0;
                    ns      = CLR;
                end
            end
            CLR: begin
                if (n_q == 5'd0) begin
                    ns     = RES;
                    cnt_nx = RES_LD;
                end else begin
                    ns = SHIFT;
                end
            end
            SHIFT: ns = MUL;
            MUL:   ns = ACC;
            ACC: begin
                if ({1'b0, idx} + 5'd1 < n_q) begin
                    idx_nx = idx + 4'd1;
                    ns     = SHIFT;
                end else begin
                    ns     = RES;
                    cnt_nx = RES_LD;
                end
            end
            RES: begin
                if (cnt == '0) ns = DONE;
                else           cnt_nx = cnt - CW'(1);
            end
            DONE:    ns = IDLE;
            default: ns = IDLE;
        endcase
        if (abort && state != IDLE) ns = IDLE;
    end

    // Outputs are decoded from the next state so they are registered yet track the state exactly.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state     <= IDLE;
            n_q       <= 5'd0;
            idx       <= 4'd0;
            cnt       <= '0;
            last_gnt  <= 1'b1;
            g_q       <= 1'b0;
            gnt       <= 2'b00;
            done      <= 2'b00;
            clr       <= 1'b0;
            shift     <= 1'b0;
            mul       <= 1'b0;
            acc       <= 1'b0;
            shift_res <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= ns;
            n_q       <= n_nx;
            idx       <= idx_nx;
            cnt       <= cnt_nx;
            last_gnt  <= last_nx;
            g_q       <= g_nx;
            gnt       <= (ns == IDLE) ? 2'b00 : (g_nx ? 2'b10 : 2'b01);
            done      <= (ns == DONE) ? (g_nx ? 2'b10 : 2'b01) : 2'b00;
            clr       <= (ns == CLR);
            shift     <= (ns == SHIFT);
            mul       <= (ns == MUL);
            acc       <= (ns == ACC);
            shift_res <= (ns == RES);
            busy      <= (ns != IDLE);
        end
    end

endmodule

// File: tb/tb_percept_sched.sv
// Bench for percept_sched: directed scenarios plus randomized evaluations against a cycle-list model.
module tb_percept_sched;

    logic       clk = 1'b0;
    logic       nRst;
    logic [1:0] req;
    logic [4:0] n_in0, n_in1;
    logic       abort;
    logic [1:0] gnt, done;
    logic       clr, shift, mul, acc, shift_res, busy;
    logic [3:0] idx;
    logic [9:0] obs;

    int n_chk  = 0;
    int n_fail = 0;
    bit lg     = 1'b1;

    percept_sched #(.N_MAX(16), .RES_BITS(8)) dut (
        .clk(clk), .nRst(nRst), .req(req), .n_in0(n_in0), .n_in1(n_in1),
        .abort(abort), .gnt(gnt), .done(done), .clr(clr), .shift(shift),
        .mul(mul), .acc(acc), .shift_res(shift_res), .idx(idx), .busy(busy)
    );

    always #5 clk = ~clk;

    assign obs = {gnt, done, clr, shift, mul, acc, shift_res, busy};

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_chk++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    // mode 0: full run; mode 1: abort at cycle cut; mode 2: reset pulse at cycle cut.
    task automatic eval(input logic [1:0] r, input logic [4:0] a, input logic [4:0] b,
                        input int mode, input int cut, input bit scramble);
        bit         w;
        int         n, total;
        logic [1:0] ge;
        logic [9:0] ev;
        req   = r;
        n_in0 = a;
        n_in1 = b;
        w     = (r == 2'b11) ? !lg : r[1];
        n     = w ? int'(b) : int'(a);
        if (n > 16) n = 16;
        lg    = w;
        ge    = w ? 2'b10 : 2'b01;
        total = 2 + 3 * n + 8;
        for (int k = 0; k < total; k++) begin
            @(posedge clk); #1;
            ev      = '0;
            ev[9:8] = ge;
            ev[0]   = 1'b1;
            if (k == 0) begin
                ev[5] = 1'b1;
                check("idx_clr", 32'(idx), 32'd0);
            end else if (k <= 3 * n) begin
                case ((k - 1) % 3)
                    0:       ev[4] = 1'b1;
                    1:       ev[3] = 1'b1;
                    default: ev[2] = 1'b1;
                endcase
                check($sformatf("idx_k%0d_n%0d", k, n), 32'(idx), 32'((k - 1) / 3));
            end else if (k <= 3 * n + 8) begin
                ev[1] = 1'b1;
            end else begin
                ev[7:6] = ge;
            end
            check($sformatf("outs_k%0d_n%0d", k, n), 32'(obs), 32'(ev));
            if (k == 0) begin
                n_in0 = 5'($urandom);
                n_in1 = 5'($urandom);
                if (scramble) req = 2'($urandom);
            end
            if (mode == 1 && k == cut) begin
                abort = 1'b1;
                @(posedge clk); #1;
                check("abort_idle", 32'(obs), 32'd0);
                abort = 1'b0;
                req   = 2'b00;
                return;
            end
            if (mode == 2 && k == cut) begin
                nRst = 1'b0;
                #1;
                check("rst_outs", 32'(obs), 32'd0);
                check("rst_idx", 32'(idx), 32'd0);
                lg  = 1'b1;
                req = 2'b00;
                #2;
                nRst = 1'b1;
                return;
            end
        end
        @(posedge clk); #1;
        check("idle_gap", 32'(obs), 32'd0);
    endtask

    initial begin
        nRst  = 1'b0;
        req   = 2'b00;
        n_in0 = 5'd0;
        n_in1 = 5'd0;
        abort = 1'b0;
        #12;
        check("reset_outs", 32'(obs), 32'd0);
        check("reset_idx", 32'(idx), 32'd0);
        #2;
        nRst = 1'b1;

        eval(2'b01, 5'd3, 5'd0, 0, 0, 1'b0);
        eval(2'b11, 5'd1, 5'd1, 0, 0, 1'b0);
        eval(2'b11, 5'd1, 5'd1, 0, 0, 1'b0);
        eval(2'b10, 5'd0, 5'd0, 0, 0, 1'b0);
        eval(2'b01, 5'd31, 5'd0, 0, 0, 1'b0);

        // Abort while idle must suppress the grant for that cycle.
        req   = 2'b01;
        abort = 1'b1;
        @(posedge clk); #1;
        check("abort_in_idle", 32'(obs), 32'd0);
        abort = 1'b0;
        req   = 2'b00;

        eval(2'b01, 5'd4, 5'd0, 1, 5, 1'b0);
        eval(2'b11, 5'd2, 5'd3, 0, 0, 1'b0);
        eval(2'b10, 5'd0, 5'd2, 2, 9, 1'b0);
        eval(2'b11, 5'd1, 5'd1, 0, 0, 1'b0);
        eval(2'b11, 5'd1, 5'd1, 0, 0, 1'b0);
        eval(2'b11, 5'd1, 5'd1, 0, 0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            eval(2'($urandom_range(1, 3)), 5'($urandom), 5'($urandom), 0, 0, 1'b1);
        end

        req = 2'b00;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
